// File: rtl/rdback_pkg.sv
// Shared widths, output phase encoding and occupancy sizing for the readback
// beat serializer.
package rdback_pkg;

   localparam int RDBK_IN_W  = 512;
   localparam int RDBK_OUT_W = 256;

   typedef enum logic {
      PH_LO = 1'b0,
      PH_HI = 1'b1
   } phase_t;

   // Occupancy must represent 0..depth inclusive, hence the extra bit.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rdback_beat_buf.sv
// Circular DEPTH x W beat buffer with push/pop and occupancy tracking; the head
// entry is presented combinationally from the registered read pointer.
module rdback_beat_buf
   import rdback_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = RDBK_IN_W
) (
   input  logic                        clk,
   input  logic                        srst,
   input  logic                        push,
   input  logic [W-1:0]                push_data,
   input  logic                        pop,
   output logic [W-1:0]                head,
   output logic [occ_width(DEPTH)-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = occ_width(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] occ_reg;

   always_ff @(posedge clk) begin
      if (!srst && push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   assign head      = mem[rd_ptr_reg];
   assign occupancy = occ_reg;

endmodule

// File: rtl/rdback_beat_serializer.sv
// Buffers 512-bit read beats and emits each as two 256-bit words (p0, then p1)
// on a valid/ready port; beats arriving with no free slot are dropped and counted.
module rdback_beat_serializer
   import rdback_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IN_W  = RDBK_IN_W,
   parameter int OUT_W = RDBK_OUT_W,
   parameter int CNT_W = 16
) (
   input  logic                       fab_clk,
   input  logic                       fab_rst,
   input  logic [IN_W-1:0]            i_rddata,
   input  logic                       i_rddata_valid,
   output logic [OUT_W-1:0]           o_word,
   output logic                       o_word_valid,
   output logic                       o_word_last,
   input  logic                       i_word_ready,
   input  logic                       i_clr_stats,
   output logic                       o_overflow,
   output logic [CNT_W-1:0]           o_drop_cnt,
   output logic [31:0]                o_beat_cnt,
   output logic [$clog2(DEPTH):0]     o_occupancy
);

   localparam int OCC_W = occ_width(DEPTH);
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

   logic [IN_W-1:0]  head;
   logic [OCC_W-1:0] occupancy;
   phase_t           phase_reg;
   logic             handshake;
   logic             push;
   logic             pop;
   logic             drop;
   logic             overflow_reg;
   logic [CNT_W-1:0] drop_cnt_reg;
   logic [31:0]      beat_cnt_reg;

   assign o_word_valid = (occupancy != '0);
   assign handshake    = o_word_valid & i_word_ready;
   assign pop          = handshake & (phase_reg == PH_HI);
   // A pop in the same cycle frees the slot the incoming beat needs.
   assign push         = i_rddata_valid & ((occupancy < FULL) | pop);
   assign drop         = i_rddata_valid & ~push;

   rdback_beat_buf #(
      .DEPTH (DEPTH),
      .W     (IN_W)
   ) u_buf (
      .clk       (fab_clk),
      .srst      (fab_rst),
      .push      (push),
      .push_data (i_rddata),
      .pop       (pop),
      .head      (head),
      .occupancy (occupancy)
   );

   always_ff @(posedge fab_clk) begin
      if (fab_rst) begin
         phase_reg <= PH_LO;
      end else if (handshake) begin
         phase_reg <= (phase_reg == PH_LO) ? PH_HI : PH_LO;
      end
   end

   // Clear wins over the old value but not over an event in the same cycle.
   always_ff @(posedge fab_clk) begin
      if (fab_rst) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
         beat_cnt_reg <= '0;
      end else if (i_clr_stats) begin
         overflow_reg <= drop;
         drop_cnt_reg <= drop ? CNT_W'(1) : '0;
         beat_cnt_reg <= push ? 32'd1 : 32'd0;
      end else begin
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != '1) begin
               drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            end
         end
         if (push) begin
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
         end
      end
   end

   assign o_word      = (phase_reg == PH_HI) ? head[IN_W-1:OUT_W] : head[OUT_W-1:0];
   assign o_word_last = (phase_reg == PH_HI);
   assign o_overflow  = overflow_reg;
   assign o_drop_cnt  = drop_cnt_reg;
   assign o_beat_cnt  = beat_cnt_reg;
   assign o_occupancy = occupancy;

endmodule

// File: tb/tb_rdback_beat_serializer.sv
// Directed-vector bench for rdback_beat_serializer: serialisation order, stalls,
// overflow/drop accounting, statistics clear and mid-operation reset.
module tb_rdback_beat_serializer;

   localparam int DEPTH = 8;
   localparam int IN_W  = 512;
   localparam int OUT_W = 256;
   localparam int CNT_W = 16;

   logic              fab_clk = 1'b0;
   logic              fab_rst;
   logic [IN_W-1:0]   i_rddata;
   logic              i_rddata_valid;
   logic [OUT_W-1:0]  o_word;
   logic              o_word_valid;
   logic              o_word_last;
   logic              i_word_ready;
   logic              i_clr_stats;
   logic              o_overflow;
   logic [CNT_W-1:0]  o_drop_cnt;
   logic [31:0]       o_beat_cnt;
   logic [3:0]        o_occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 fab_clk = ~fab_clk;

   rdback_beat_serializer #(
      .DEPTH (DEPTH),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .CNT_W (CNT_W)
   ) dut (
      .fab_clk        (fab_clk),
      .fab_rst        (fab_rst),
      .i_rddata       (i_rddata),
      .i_rddata_valid (i_rddata_valid),
      .o_word         (o_word),
      .o_word_valid   (o_word_valid),
      .o_word_last    (o_word_last),
      .i_word_ready   (i_word_ready),
      .i_clr_stats    (i_clr_stats),
      .o_overflow     (o_overflow),
      .o_drop_cnt     (o_drop_cnt),
      .o_beat_cnt     (o_beat_cnt),
      .o_occupancy    (o_occupancy)
   );

   function automatic logic [OUT_W-1:0] lo_of(input int k);
      return 256'hA000 + 256'(k);
   endfunction

   function automatic logic [OUT_W-1:0] hi_of(input int k);
      return 256'hB000 + 256'(k);
   endfunction

   task automatic step();
      @(posedge fab_clk);
      #1;
   endtask

   task automatic push_beats(input int first, input int last_k);
      for (int k = first; k <= last_k; k++) begin
         i_rddata       = {hi_of(k), lo_of(k)};
         i_rddata_valid = 1'b1;
         step();
         $display("push beat %0d: occ=%0d drop=%0d", k, o_occupancy, o_drop_cnt);
      end
      i_rddata_valid = 1'b0;
   endtask

   task automatic test_reset();
      fab_rst = 1'b1;
      step();
      step();
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_word_valid); end
      n_checks++; if (o_word_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", o_word_last); end
      n_checks++; if (o_occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", o_occupancy); end
      n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", o_overflow); end
      n_checks++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", o_drop_cnt); end
      n_checks++; if (o_beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_beat: got %0d want 0", o_beat_cnt); end
      fab_rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_beat();
      i_word_ready   = 1'b1;
      i_rddata       = {256'hB, 256'hA};
      i_rddata_valid = 1'b1;
      step();
      i_rddata_valid = 1'b0;
      n_checks++; if (o_word_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_lo: got %0b want 1", o_word_valid); end
      n_checks++; if (o_word !== 256'hA) begin n_fail++; $display("FAIL single_word_lo: got %h want a", o_word); end
      n_checks++; if (o_word_last !== 1'b0) begin n_fail++; $display("FAIL single_last_lo: got %0b want 0", o_word_last); end
      step();
      n_checks++; if (o_word !== 256'hB) begin n_fail++; $display("FAIL single_word_hi: got %h want b", o_word); end
      n_checks++; if (o_word_last !== 1'b1) begin n_fail++; $display("FAIL single_last_hi: got %0b want 1", o_word_last); end
      step();
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_end: got %0b want 0", o_word_valid); end
      n_checks++; if (o_beat_cnt !== 32'd1) begin n_fail++; $display("FAIL single_beat_cnt: got %0d want 1", o_beat_cnt); end
      $display("test_single_beat done");
   endtask

   task automatic test_stall();
      i_word_ready = 1'b0;
      push_beats(1, 1);
      for (int c = 0; c < 5; c++) begin
         n_checks++; if (o_word_valid !== 1'b1 || o_word !== lo_of(1) || o_word_last !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold cycle %0d: got v=%0b l=%0b w=%h want v=1 l=0 w=%h", c, o_word_valid, o_word_last, o_word, lo_of(1));
         end
         step();
      end
      i_word_ready = 1'b1;
      n_checks++; if (o_word !== lo_of(1)) begin n_fail++; $display("FAIL stall_release_lo: got %h want %h", o_word, lo_of(1)); end
      step();
      n_checks++; if (o_word !== hi_of(1) || o_word_last !== 1'b1) begin n_fail++; $display("FAIL stall_release_hi: got %h l=%0b want %h l=1", o_word, o_word_last, hi_of(1)); end
      step();
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid: got %0b want 0", o_word_valid); end
      $display("test_stall done");
   endtask

   task automatic test_back_to_back();
      logic [OUT_W-1:0] exp_w [6];
      logic             exp_l [6];
      exp_w[0] = lo_of(1); exp_w[1] = hi_of(1); exp_w[2] = lo_of(2);
      exp_w[3] = hi_of(2); exp_w[4] = lo_of(3); exp_w[5] = hi_of(3);
      exp_l[0] = 1'b0; exp_l[1] = 1'b1; exp_l[2] = 1'b0;
      exp_l[3] = 1'b1; exp_l[4] = 1'b0; exp_l[5] = 1'b1;
      i_word_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            i_rddata       = {hi_of(c + 1), lo_of(c + 1)};
            i_rddata_valid = 1'b1;
         end else begin
            i_rddata_valid = 1'b0;
         end
         step();
         n_checks++; if (o_word_valid !== 1'b1 || o_word !== exp_w[c] || o_word_last !== exp_l[c]) begin
            n_fail++; $display("FAIL b2b word %0d: got v=%0b l=%0b w=%h want v=1 l=%0b w=%h", c, o_word_valid, o_word_last, o_word, exp_l[c], exp_w[c]);
         end
      end
      i_rddata_valid = 1'b0;
      step();
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %0b want 0", o_word_valid); end
      $display("test_back_to_back done");
   endtask

   task automatic test_overflow();
      i_clr_stats = 1'b1;
      step();
      i_clr_stats  = 1'b0;
      i_word_ready = 1'b0;
      push_beats(1, 10);
      n_checks++; if (o_occupancy !== 4'd8) begin n_fail++; $display("FAIL ovf_occ: got %0d want 8", o_occupancy); end
      n_checks++; if (o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want 2", o_drop_cnt); end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", o_overflow); end
      n_checks++; if (o_beat_cnt !== 32'd8) begin n_fail++; $display("FAIL ovf_beat: got %0d want 8", o_beat_cnt); end
      i_word_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         n_checks++; if (o_word !== lo_of(k) || o_word_last !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_lo %0d: got %h want %h", k, o_word, lo_of(k)); end
         step();
         n_checks++; if (o_word !== hi_of(k) || o_word_last !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_hi %0d: got %h want %h", k, o_word, hi_of(k)); end
         step();
      end
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid: got %0b want 0", o_word_valid); end
      $display("test_overflow done");
   endtask

   task automatic test_full_pop_push();
      i_clr_stats = 1'b1;
      step();
      i_clr_stats  = 1'b0;
      i_word_ready = 1'b0;
      push_beats(1, 8);
      i_word_ready = 1'b1;
      step();
      n_checks++; if (o_word_last !== 1'b1) begin n_fail++; $display("FAIL fpp_phase_hi: got %0b want 1", o_word_last); end
      i_rddata       = {hi_of(9), lo_of(9)};
      i_rddata_valid = 1'b1;
      step();
      i_rddata_valid = 1'b0;
      n_checks++; if (o_occupancy !== 4'd8) begin n_fail++; $display("FAIL fpp_occ: got %0d want 8", o_occupancy); end
      n_checks++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL fpp_drop: got %0d want 0", o_drop_cnt); end
      n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0b want 0", o_overflow); end
      n_checks++; if (o_beat_cnt !== 32'd9) begin n_fail++; $display("FAIL fpp_beat: got %0d want 9", o_beat_cnt); end
      for (int k = 2; k <= 9; k++) begin
         n_checks++; if (o_word !== lo_of(k)) begin n_fail++; $display("FAIL fpp_drain_lo %0d: got %h want %h", k, o_word, lo_of(k)); end
         step();
         n_checks++; if (o_word !== hi_of(k)) begin n_fail++; $display("FAIL fpp_drain_hi %0d: got %h want %h", k, o_word, hi_of(k)); end
         step();
      end
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained_valid: got %0b want 0", o_word_valid); end
      $display("test_full_pop_push done");
   endtask

   task automatic test_clr_stats();
      i_word_ready = 1'b0;
      push_beats(1, 8);
      i_rddata       = {hi_of(20), lo_of(20)};
      i_rddata_valid = 1'b1;
      i_clr_stats    = 1'b1;
      step();
      i_rddata_valid = 1'b0;
      i_clr_stats    = 1'b0;
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL clr_drop_overflow: got %0b want 1", o_overflow); end
      n_checks++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_drop_cnt: got %0d want 1", o_drop_cnt); end
      n_checks++; if (o_beat_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_drop_beat: got %0d want 0", o_beat_cnt); end
      n_checks++; if (o_occupancy !== 4'd8) begin n_fail++; $display("FAIL clr_drop_occ: got %0d want 8", o_occupancy); end
      i_word_ready = 1'b1;
      step();
      i_rddata       = {hi_of(21), lo_of(21)};
      i_rddata_valid = 1'b1;
      i_clr_stats    = 1'b1;
      step();
      i_rddata_valid = 1'b0;
      i_clr_stats    = 1'b0;
      i_word_ready   = 1'b0;
      n_checks++; if (o_beat_cnt !== 32'd1) begin n_fail++; $display("FAIL clr_push_beat: got %0d want 1", o_beat_cnt); end
      n_checks++; if (o_drop_cnt !== 16'd0 || o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_push_stats: got drop=%0d ovf=%0b want 0 0", o_drop_cnt, o_overflow); end
      n_checks++; if (o_word !== lo_of(2) || o_occupancy !== 4'd8) begin n_fail++; $display("FAIL clr_push_head: got %h occ=%0d want %h occ=8", o_word, o_occupancy, lo_of(2)); end
      $display("test_clr_stats done");
   endtask

   task automatic test_reset_mid();
      fab_rst = 1'b1;
      step();
      fab_rst      = 1'b0;
      i_word_ready = 1'b0;
      push_beats(1, 3);
      i_word_ready = 1'b1;
      step();
      i_word_ready = 1'b0;
      n_checks++; if (o_word_last !== 1'b1 || o_occupancy !== 4'd3) begin n_fail++; $display("FAIL rmid_pre: got l=%0b occ=%0d want l=1 occ=3", o_word_last, o_occupancy); end
      fab_rst        = 1'b1;
      i_rddata       = {hi_of(7), lo_of(7)};
      i_rddata_valid = 1'b1;
      step();
      fab_rst        = 1'b0;
      i_rddata_valid = 1'b0;
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", o_word_valid); end
      n_checks++; if (o_occupancy !== 4'd0) begin n_fail++; $display("FAIL rmid_occ: got %0d want 0", o_occupancy); end
      n_checks++; if (o_beat_cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_beat: got %0d want 0", o_beat_cnt); end
      push_beats(5, 5);
      n_checks++; if (o_word !== lo_of(5) || o_word_last !== 1'b0 || o_occupancy !== 4'd1) begin
         n_fail++; $display("FAIL rmid_new_lo: got %h l=%0b occ=%0d want %h l=0 occ=1", o_word, o_word_last, o_occupancy, lo_of(5));
      end
      i_word_ready = 1'b1;
      step();
      n_checks++; if (o_word !== hi_of(5) || o_word_last !== 1'b1) begin n_fail++; $display("FAIL rmid_new_hi: got %h l=%0b want %h l=1", o_word, o_word_last, hi_of(5)); end
      step();
      n_checks++; if (o_word_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_end_valid: got %0b want 0", o_word_valid); end
      $display("test_reset_mid done");
   endtask

   initial begin
      fab_rst        = 1'b1;
      i_rddata       = '0;
      i_rddata_valid = 1'b0;
      i_word_ready   = 1'b0;
      i_clr_stats    = 1'b0;
      test_reset();
      test_single_beat();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_full_pop_push();
      test_clr_stats();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rdback_beat_serializer.md
Name: rdback_beat_serializer

Overview:
- Sits in the fab_clk domain directly downstream of the HBM-to-DRAM-Bender read-data CDC FIFO.
- Input: 512-bit read beats {p1,p0}, a single-cycle valid, no backpressure.
- Buffers beats and serialises each into two 256-bit words (p0 first, then p1) on a valid/ready interface to the readback engine.
- Detects and counts beats lost to buffer overflow.

Parameters:
- DEPTH, 8, beat buffer entries; power of two, >=2.
- IN_W, 512, input beat width.
- OUT_W, 256, output word width; IN_W = 2*OUT_W.
- CNT_W, 16, width of the drop counter.

Ports:
- fab_clk  input  1  fabric clock; all logic is on its rising edge.
- fab_rst  input  1  synchronous, active-high reset.
- i_rddata  input  IN_W  read beat, {p1[255:0], p0[255:0]}.
- i_rddata_valid  input  1  beat present this cycle; no backpressure upstream.
- o_word  output  OUT_W  serialised word.
- o_word_valid  output  1  o_word is valid.
- o_word_last  output  1  o_word is the p1 (upper) half of its beat.
- i_word_ready  input  1  consumer accepts the word when valid & ready.
- i_clr_stats  input  1  one-cycle pulse; clears the overflow flag and counters.
- o_overflow  output  1  sticky; set when a beat is dropped.
- o_drop_cnt  output  CNT_W  beats dropped; saturates at all-ones.
- o_beat_cnt  output  32  beats accepted; wraps modulo 2^32.
- o_occupancy  output  $clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset: fab_rst high at a clock edge clears:
  - the buffer pointers and occupancy,
  - phase to LO,
  - o_word_valid and o_word_last,
  - o_overflow, o_drop_cnt and o_beat_cnt.
- o_word is don't-care while o_word_valid = 0.
- Reset mid-operation discards all buffered data and the in-flight half immediately. i_rddata_valid in the reset cycle is ignored.
- Buffer: circular array of DEPTH x IN_W with read/write pointers of $clog2(DEPTH) bits, wrapping naturally. Occupancy counts 0..DEPTH.
- pop: asserted when o_word_valid & i_word_ready & phase == HI, i.e. the second half is accepted.
- push: i_rddata_valid & (occupancy < DEPTH | pop). When full, a simultaneous pop frees the slot and the new beat is accepted.
- Drop: i_rddata_valid & ~push. The beat is discarded, o_overflow is set and o_drop_cnt is incremented with saturation.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on both or neither.
- o_beat_cnt increments on every push.
- Output phase FSM:
  - LO: o_word = head[OUT_W-1:0], o_word_last = 0. On handshake -> HI.
  - HI: o_word = head[IN_W-1:OUT_W], o_word_last = 1. On handshake, pop -> LO.
  - The FSM advances only on handshake; data and last stay stable while valid & ~ready.
- o_word_valid = (occupancy != 0). Valid/data are driven from registered state: buffer head and phase.
- Latency:
  - A beat pushed at edge N into an empty buffer gives o_word_valid = 1 after edge N (visible in cycle N+1).
  - Back-to-back with ready held high: one word per cycle, two cycles per beat.
- Sustained input at one beat per cycle overflows by design; o_overflow reports it.
- i_clr_stats clears o_overflow, o_drop_cnt and o_beat_cnt.
  - If a drop coincides with the clear, the result is o_overflow = 1 and o_drop_cnt = 1.
  - If a push coincides with the clear, the result is o_beat_cnt = 1.
- i_clr_stats does not touch buffer contents or the FSM.
- No zero-half filtering: all-zero halves (inactive pseudo-channel) are forwarded unchanged.

Decomposition:
- Shared package rdback_pkg holds:
  - RDBK_IN_W = 512 and RDBK_OUT_W = 256,
  - the phase enum {PH_LO, PH_HI},
  - the function clog2-based occupancy width.
- One natural sub-module: rdback_beat_buf, the DEPTH x IN_W circular buffer with push/pop/occupancy and head output. It contains no drop logic.
- FSM, counters and drop logic live in the top.

Test Plan:
- Single beat {p1=256'hB, p0=256'hA}, ready = 1:
  - cycle N+1: o_word = A, last = 0;
  - cycle N+2: o_word = B, last = 1;
  - cycle N+3: o_word_valid = 0, o_beat_cnt = 1.
- Ready held low for 5 cycles with one beat buffered: o_word = A, valid = 1 and last = 0 stay stable. Ready high then yields A, then B.
- Ready = 0 with 10 consecutive input beats (DEPTH = 8):
  - o_occupancy = 8, o_drop_cnt = 2, o_overflow = 1;
  - draining outputs exactly beats 1..8 in order.
- Full buffer, pop of HI and new beat in the same cycle: beat accepted, occupancy stays 8, o_drop_cnt unchanged.
- i_clr_stats pulsed in the same cycle as a drop: next cycle o_overflow = 1, o_drop_cnt = 1.
- fab_rst asserted while phase = HI with 3 beats held:
  - next cycle o_word_valid = 0 and o_occupancy = 0;
  - a new beat after reset emits its LO half first.
